reset_sequencer: RTL
====================

// Module: reset_sequencer
// PURPOSE
//  Synthesizable reset controller for the core top level. Takes the board
//  clock and raw async reset, holds all domains in reset for a fixed period,
//  then releases NUM_CH reset channels one at a time, STAGGER cycles apart.
//  Adds a software reset request and a watchdog. Reports the cause of the
//  last reset. Sits between the clock/reset pins and core/memory/peripherals.
// PARAMETERS
//  NUM_CH      4     number of reset outputs; ch0 is released first
//  HOLD_CYCLES 16    cycles all channels stay asserted before staged release (>=1)
//  STAGGER     4     cycles between successive channel releases (>=1)
//  WDT_CYCLES  64    cycles without a kick before the watchdog fires (>=2)
// PORTS
//  clock        in   1       system clock
//  reset        in   1       async active-high raw reset (power-on)
//  sw_rst_req   in   1       1-cycle pulse: software reset request
//  wdt_en       in   1       watchdog enable, sampled every cycle in RUN
//  wdt_kick     in   1       clears the watchdog counter
//  ch_reset     out  NUM_CH  per-domain reset, active-high, registered
//  all_released out  1       1 while the FSM is in RUN
//  rst_cause    out  2       01=POR, 10=SW, 11=WDT (00 never driven)
// BEHAVIOUR
//  - Async assert: reset=1 forces state=HOLD, ch_reset='1, all_released=0,
//    rst_cause=01, cnt=0, idx=0, wdt_cnt=0. Deassert is synchronous.
//    The first rising edge with reset=0 is edge 1.
//  - FSM HOLD: cnt increments each edge. When cnt==HOLD_CYCLES-1, go to
//    RELEASE and set cnt=0. HOLD therefore covers edges 1..HOLD_CYCLES.
//  - FSM RELEASE: cnt increments each edge. When cnt==STAGGER-1, clear
//    ch_reset[idx], increment idx, and set cnt=0. Channel k deasserts on edge
//    HOLD_CYCLES+(k+1)*STAGGER. On the edge that clears ch NUM_CH-1, go to RUN
//    and set all_released=1 on the same edge.
//  - FSM RUN: ch_reset=0.
//    - If wdt_en=1, wdt_cnt increments each edge. wdt_kick=1 sets wdt_cnt=0.
//    - If wdt_en=0, wdt_cnt is held at 0.
//    - The watchdog fires on an edge where wdt_cnt==WDT_CYCLES-1, wdt_kick=0
//      and wdt_en=1.
//  - Reset entry, from SW request (any state) or watchdog fire (RUN only):
//    on that edge set ch_reset='1, all_released=0, state=HOLD, cnt=0, idx=0,
//    wdt_cnt=0, and rst_cause=10 (SW) or 11 (WDT). The full sequence then
//    replays.
//  - Priority: raw reset > sw_rst_req > watchdog fire > wdt_kick > normal
//    counting. A kick on the expiry edge prevents the fire.
//  - sw_rst_req in HOLD or RELEASE restarts HOLD. Already-released channels
//    re-assert.
//  - rst_cause holds its value until the next reset event.
//  - Counter widths: $clog2 of the largest of HOLD_CYCLES, STAGGER and
//    WDT_CYCLES, plus 1. No wrap is possible because every counter is
//    bounded by its compare.
//  - All outputs come straight from flops; no combinational path from inputs.
// TESTING (defaults)
//  1. POR: assert reset for 1 cycle, then release
//     -> ch_reset 1111 until edge 20; bit0 clears at 20, bit1 at 24,
//        bit2 at 28, bit3 at 32; all_released=1 at 32; rst_cause=01.
//  2. SW in RUN: pulse sw_rst_req at edge 40
//     -> ch_reset=1111 and all_released=0 at edge 40; rst_cause=10;
//        bit0 clears at edge 60.
//  3. WDT: RUN with wdt_en=1 and no kick -> fires 64 edges after entering RUN,
//     ch_reset=1111, rst_cause=11. Kicking every 50 cycles -> never fires.
//  4. Simultaneous: sw_rst_req together with the WDT expiry edge -> rst_cause=10.
//     Kick on the expiry edge -> no reset.
//  5. Mid-sequence: sw_rst_req at edge 26 (ch0 and ch1 released)
//     -> ch_reset=1111 at 26; ch0 re-releases at edge 46.
//  6. Async reset mid-RELEASE, asserted between edges -> ch_reset=1111
//     immediately, without waiting for a clock edge; rst_cause=01.

Source files
------------

// File: rtl/reset_sequencer.sv
// Power-on / software / watchdog reset controller: holds every domain in reset,
// then releases the channels one by one and supervises RUN with a watchdog.
module reset_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4,
    parameter int WDT_CYCLES  = 64
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              sw_rst_req_i,
    input  logic              wdt_en_i,
    input  logic              wdt_kick_i,
    output logic [NUM_CH-1:0] ch_reset_o,
    output logic              all_released_o,
    output logic [1:0]        rst_cause_o
);

    // state   | meaning
    // HOLD    | all channels asserted, counting HOLD_CYCLES
    // RELEASE | deasserting one channel every STAGGER cycles, ch0 first
    // RUN     | all channels released, watchdog active when enabled
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam int MAX_HS = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int MAX_C  = (MAX_HS > WDT_CYCLES) ? MAX_HS : WDT_CYCLES;
    localparam int CW     = $clog2(MAX_C) + 1;
    localparam int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);
    localparam logic [CW-1:0] WDT_LAST  = CW'(WDT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

    localparam logic [1:0] CAUSE_POR = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     wdt_cnt_q, wdt_cnt_d;
    logic [NUM_CH-1:0] ch_reset_q, ch_reset_d;
    logic              all_rel_q, all_rel_d;
    logic [1:0]        cause_q, cause_d;
    logic              enter_rst;
    logic [1:0]        enter_cause;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdt_cnt_q  <= '0;
            ch_reset_q <= '1;
            all_rel_q  <= 1'b0;
            cause_q    <= CAUSE_POR;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdt_cnt_q  <= wdt_cnt_d;
            ch_reset_q <= ch_reset_d;
            all_rel_q  <= all_rel_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdt_cnt_d   = wdt_cnt_q;
        ch_reset_d  = ch_reset_q;
        all_rel_d   = all_rel_q;
        cause_d     = cause_q;
        enter_rst   = 1'b0;
        enter_cause = CAUSE_SW;

        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == STAG_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (idx_q == IW'(i)) ch_reset_d[i] = 1'b0;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d   = ST_RUN;
                        all_rel_d = 1'b1;
                        idx_d     = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                ch_reset_d = '0;
                // A kick on the expiry edge wins over the fire.
                if (wdt_en_i && !wdt_kick_i && wdt_cnt_q == WDT_LAST) begin
                    enter_rst   = 1'b1;
                    enter_cause = CAUSE_WDT;
                end else if (wdt_kick_i || !wdt_en_i) begin
                    wdt_cnt_d = '0;
                end else begin
                    wdt_cnt_d = wdt_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        if (sw_rst_req_i) begin
            enter_rst   = 1'b1;
            enter_cause = CAUSE_SW;
        end

        if (enter_rst) begin
            state_d    = ST_HOLD;
            cnt_d      = '0;
            idx_d      = '0;
            wdt_cnt_d  = '0;
            ch_reset_d = '1;
            all_rel_d  = 1'b0;
            cause_d    = enter_cause;
        end
    end

    assign ch_reset_o     = ch_reset_q;
    assign all_released_o = all_rel_q;
    assign rst_cause_o    = cause_q;

endmodule
